// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between pipeline stages and the stall/flush scheduler.
// Stages drive requests (master); pipe_ctrl drives stall/flush controls (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_stall_req;
  logic             ex_busy_req;
  logic             ex_done;
  logic             mem_stall_req;
  logic             flush_req;
  logic [31:0]      flush_pc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             ex_abort;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_stall_req, ex_busy_req, ex_done, mem_stall_req, flush_req, flush_pc,
    input  stall, flush, new_pc, ex_abort, timeout_err, stall_cnt
  );

  modport slave (
    input  id_stall_req, ex_busy_req, ex_done, mem_stall_req, flush_req, flush_pc,
    output stall, flush, new_pc, ex_abort, timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler: stall is combinational (same cycle), flush/new_pc/ex_abort registered (1 cycle).
// Waits on EX/MEM are bounded by TIMEOUT_CYCLES, after which a flush is forced and timeout_err sticks.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0] ST_MEM  = 6'b011111;
  localparam logic [5:0] ST_EX   = 6'b001111;
  localparam logic [5:0] ST_ID   = 6'b000111;
  localparam logic [5:0] ST_NONE = 6'b000000;

  typedef enum logic [1:0] {RUN, EX_WAIT, MEM_WAIT, FLUSH} state_t;

  state_t           r_state, w_nxt;
  logic [WCW-1:0]   r_wcnt, w_wcnt_nxt;
  logic [31:0]      r_pc;
  logic             r_flush, r_abort, r_tmo;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       w_stall, w_stall_out;
  logic             w_latch, w_abort, w_tmo, w_tmo_hit;

  assign w_tmo_hit = (r_wcnt == WCW'(TIMEOUT_CYCLES));

  always_comb begin
    w_nxt      = r_state;
    w_wcnt_nxt = r_wcnt;
    w_stall    = ST_NONE;
    w_latch    = 1'b0;
    w_abort    = 1'b0;
    w_tmo      = 1'b0;
    unique case (r_state)
      RUN: begin
        if (bus.flush_req) begin
          w_nxt   = FLUSH;
          w_latch = 1'b1;
        end else if (bus.mem_stall_req) begin
          w_stall    = ST_MEM;
          w_nxt      = MEM_WAIT;
          w_wcnt_nxt = WCW'(1);
        end else if (bus.ex_busy_req) begin
          w_stall = ST_EX;
          if (!bus.ex_done) begin
            w_nxt      = EX_WAIT;
            w_wcnt_nxt = WCW'(1);
          end
        end else if (bus.id_stall_req) begin
          w_stall = ST_ID;
        end
      end
      EX_WAIT: begin
        w_wcnt_nxt = r_wcnt + WCW'(1);
        if (bus.flush_req) begin
          w_nxt   = FLUSH;
          w_latch = 1'b1;
          w_abort = 1'b1;
        end else if (bus.ex_done) begin
          // A MEM stall arriving with ex_done still has to be honoured.
          if (bus.mem_stall_req) begin
            w_stall    = ST_MEM;
            w_nxt      = MEM_WAIT;
            w_wcnt_nxt = WCW'(1);
          end else begin
            w_nxt = RUN;
          end
        end else if (w_tmo_hit) begin
          w_nxt   = FLUSH;
          w_abort = 1'b1;
          w_tmo   = 1'b1;
        end else begin
          w_stall = bus.mem_stall_req ? ST_MEM : ST_EX;
        end
      end
      MEM_WAIT: begin
        w_wcnt_nxt = r_wcnt + WCW'(1);
        if (!bus.mem_stall_req) begin
          w_nxt = RUN;
        end else if (w_tmo_hit) begin
          w_nxt = FLUSH;
          w_tmo = 1'b1;
        end else begin
          w_stall = ST_MEM;
        end
      end
      FLUSH: begin
        w_nxt = RUN;
      end
      default: begin
        w_nxt = RUN;
      end
    endcase
  end

  // Reset gates stall directly so it drops without waiting for a clock.
  assign w_stall_out = rst ? w_stall : ST_NONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_wcnt  <= '0;
      r_pc    <= '0;
      r_flush <= 1'b0;
      r_abort <= 1'b0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_flush <= (w_nxt == FLUSH);
      r_abort <= w_abort;
      r_tmo   <= r_tmo | w_tmo;
      if (w_latch) r_pc <= bus.flush_pc;
      if (w_stall_out[0] && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.stall       = w_stall_out;
  assign bus.flush       = r_flush;
  assign bus.new_pc      = r_pc;
  assign bus.ex_abort    = r_abort;
  assign bus.timeout_err = r_tmo;
  assign bus.stall_cnt   = r_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus reset, timeout and saturation sequences.
module tb_pipe_ctrl;
  localparam int TMO = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id, exb, exd, mem, fl;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush, e_abort, e_tmo;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic id, exb, exd, mem, fl, input logic [31:0] pc,
                     input logic [5:0] st, input logic ef, ea, et,
                     input logic [31:0] epc, input int ec);
    vec_t v;
    v.id = id; v.exb = exb; v.exd = exd; v.mem = mem; v.fl = fl; v.pc = pc;
    v.e_stall = st; v.e_flush = ef; v.e_abort = ea; v.e_tmo = et; v.e_pc = epc; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, exb, exd, mem, fl, input logic [31:0] pc);
    bus.id_stall_req = id; bus.ex_busy_req = exb; bus.ex_done = exd;
    bus.mem_stall_req = mem; bus.flush_req = fl; bus.flush_pc = pc;
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0, 0, 0);

    // Reset with random request inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      #1;
      chk("rst_stall", 32'(bus.stall), 0);
      chk("rst_flush", 32'(bus.flush), 0);
      chk("rst_new_pc", bus.new_pc, 0);
      chk("rst_cnt", 32'(bus.stall_cnt), 0);
      chk("rst_tmo", 32'(bus.timeout_err), 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    //   id exb exd mem fl pc        stall      fl ab to e_pc      cnt
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         0);
    add(1, 0, 0, 0, 0, 0,         6'b000111, 0, 0, 0, 0,         0);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         1);
    add(0, 1, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         1);
    add(0, 0, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         2);
    add(0, 0, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         3);
    add(0, 0, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         4);
    add(0, 0, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         5);
    add(0, 0, 1, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         6);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         6);
    add(0, 1, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         6);
    add(0, 0, 0, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         7);
    add(0, 0, 0, 0, 1, 32'h40,    6'b000000, 0, 0, 0, 0,         8);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 1, 1, 0, 32'h40,    8);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         8);
    add(0, 0, 0, 1, 1, 32'h80,    6'b000000, 0, 0, 0, 0,         8);
    add(0, 0, 0, 1, 0, 0,         6'b000000, 1, 0, 0, 32'h80,    8);
    add(0, 0, 0, 1, 0, 0,         6'b011111, 0, 0, 0, 0,         8);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         9);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         9);
    add(0, 1, 1, 0, 0, 0,         6'b001111, 0, 0, 0, 0,         9);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         10);
    add(1, 0, 0, 1, 0, 0,         6'b011111, 0, 0, 0, 0,         10);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         11);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         11);
    add(0, 0, 0, 1, 0, 0,         6'b011111, 0, 0, 0, 0,         11);
    add(0, 0, 0, 1, 1, 32'hC0,    6'b011111, 0, 0, 0, 0,         12);
    add(0, 0, 0, 0, 1, 32'hC0,    6'b000000, 0, 0, 0, 0,         13);
    add(0, 0, 0, 0, 1, 32'hC0,    6'b000000, 0, 0, 0, 0,         13);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 1, 0, 0, 32'hC0,    13);
    add(0, 0, 0, 0, 0, 0,         6'b000000, 0, 0, 0, 0,         13);

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d_abort", i), 32'(bus.ex_abort), 32'(tbl[i].e_abort));
      chk($sformatf("v%0d_tmo", i), 32'(bus.timeout_err), 32'(tbl[i].e_tmo));
      chk($sformatf("v%0d_cnt", i), 32'(bus.stall_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_flush) chk($sformatf("v%0d_new_pc", i), bus.new_pc, tbl[i].e_pc);
      drive(tbl[i].id, tbl[i].exb, tbl[i].exd, tbl[i].mem, tbl[i].fl, tbl[i].pc);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
    end

    // Reset asserted mid-wait: stall drops at once, no abort afterwards
    @(negedge clk); drive(0, 1, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 0, 0);
    #1 chk("mw_stall_pre", 32'(bus.stall), 32'(6'b011111));
    #1 rst = 1'b0;
    #1 chk("mw_stall_async", 32'(bus.stall), 0);
    chk("mw_cnt", 32'(bus.stall_cnt), 0);
    chk("mw_tmo", 32'(bus.timeout_err), 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); rst = 1'b1;
    #1 chk("mw_stall_run", 32'(bus.stall), 0);
    @(negedge clk);
    chk("mw_abort", 32'(bus.ex_abort), 0);
    chk("mw_flush", 32'(bus.flush), 0);

    // MEM wait timeout
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(0, 0, 0, 1, 0, 0);
      #1;
      if (bus.stall != 6'b011111) break;
      n++;
    end
    chk("mt_stall_cycles", 32'(n), TMO);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    chk("mt_flush", 32'(bus.flush), 1);
    chk("mt_tmo", 32'(bus.timeout_err), 1);
    chk("mt_abort", 32'(bus.ex_abort), 0);
    chk("mt_new_pc", bus.new_pc, 0);
    @(negedge clk);
    chk("mt_flush_drop", 32'(bus.flush), 0);
    chk("mt_tmo_sticky", 32'(bus.timeout_err), 1);
    chk("mt_cnt", 32'(bus.stall_cnt), TMO);

    // EX wait timeout; stall counter saturates at 15
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(0, (i == 0), 0, 0, 0, 0);
      #1;
      if (bus.stall != 6'b001111) break;
      n++;
    end
    chk("et_stall_cycles", 32'(n), TMO);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    chk("et_flush", 32'(bus.flush), 1);
    chk("et_abort", 32'(bus.ex_abort), 1);
    chk("et_tmo", 32'(bus.timeout_err), 1);
    chk("et_cnt_sat", 32'(bus.stall_cnt), 15);
    @(negedge clk);
    chk("et_abort_drop", 32'(bus.ex_abort), 0);
    chk("et_cnt_hold", 32'(bus.stall_cnt), 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
